// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequence checker and any generator model
// that has to predict the same stream.
package lfsr_pkg;

  localparam int LFSR_W = 8;

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} chk_state_t;

  // One shift of the two-tap generator: feedback enters at the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v,
                                                   input int t1, input int t2);
    return {v[0] ^ v[t1[2:0]] ^ v[t2[2:0]], v[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr_period_meter.sv
// Period meter for the LFSR checker. Built only when LFSR_CHK_PERIOD_EN is
// defined; otherwise this file is empty and the checker ties period to zero.
`ifdef LFSR_CHK_PERIOD_EN
module lfsr_period_meter
  import lfsr_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic              in_locked,
  input  logic [LFSR_W-1:0] sample,
  output logic [CNT_W-1:0]  period,
  output logic              period_valid
);

  logic              armed_q, armed_d;
  logic [LFSR_W-1:0] ref_q, ref_d;
  logic [CNT_W-1:0]  run_q, run_d, run_inc;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              pvalid_q, pvalid_d;

  assign run_inc = (run_q == '1) ? run_q : run_q + 1'b1;

  // Arm on the first locked sample, then time the distance back to it.
  always_comb begin
    armed_d  = armed_q;
    ref_d    = ref_q;
    run_d    = run_q;
    period_d = period_q;
    pvalid_d = 1'b0;
    if (clear) begin
      armed_d  = 1'b0;
      ref_d    = '0;
      run_d    = '0;
      period_d = '0;
    end else if (!in_locked) begin
      // Lock lost: forget the reference, keep the last measurement.
      armed_d = 1'b0;
    end else if (sample_valid) begin
      if (!armed_q) begin
        armed_d = 1'b1;
        ref_d   = sample;
        run_d   = '0;
      end else if (sample == ref_q) begin
        period_d = run_inc;
        pvalid_d = 1'b1;
        run_d    = '0;
      end else begin
        run_d = run_inc;
      end
    end
  end

  // Meter state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed_q  <= 1'b0;
      ref_q    <= '0;
      run_q    <= '0;
      period_q <= '0;
      pvalid_q <= 1'b0;
    end else begin
      armed_q  <= armed_d;
      ref_q    <= ref_d;
      run_q    <= run_d;
      period_q <= period_d;
      pvalid_q <= pvalid_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pvalid_q;

endmodule
`endif

// File: rtl/lfsr_seq_checker.sv
// Health checker for the two-tap 8-bit LFSR generator: predicts each sample,
// declares lock, counts mispredictions and flags the all-zero lockup value.
// Define LFSR_CHK_PERIOD_EN to include the sequence period meter.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned TAP_ONE    = 2,
  parameter int unsigned TAP_TWO    = 4,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic [LFSR_W-1:0] lfsr_in,
  input  logic              clear,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic              stuck_zero,
  output logic [CNT_W-1:0]  period,
  output logic              period_valid
);

  localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);
  localparam logic [3:0] LossCnt = 4'(LOSS_COUNT);

  chk_state_t        state_q, state_d;
  logic [LFSR_W-1:0] prev_q, prev_d;
  logic [3:0]        match_cnt_q, match_cnt_d;
  logic [3:0]        miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              stuck_q, stuck_d;
  logic              err_pulse_q, err_pulse_d;
  logic [LFSR_W-1:0] expected;
  logic              match;

  assign expected = lfsr_next(prev_q, int'(TAP_ONE), int'(TAP_TWO));
  // A zero sample never counts as correct, even if predicted from zero.
  assign match    = (lfsr_in == expected) && (lfsr_in != '0);

  // Lock FSM and counters; only accepted samples advance anything.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_count_d = err_count_q;
    stuck_d     = stuck_q;
    err_pulse_d = 1'b0;
    if (clear) begin
      state_d     = HUNT;
      prev_d      = '0;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
      err_count_d = '0;
      stuck_d     = 1'b0;
    end else if (valid) begin
      prev_d  = lfsr_in;
      stuck_d = (lfsr_in == '0);
      unique case (state_q)
        HUNT: begin
          state_d     = SYNC;
          match_cnt_d = '0;
        end
        SYNC: begin
          if (match) begin
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_q + 4'd1 == LockCnt) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            miss_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;
            miss_cnt_d  = miss_cnt_q + 4'd1;
            if (miss_cnt_q + 4'd1 == LossCnt) begin
              state_d     = SYNC;
              match_cnt_d = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Checker state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_count_q <= '0;
      stuck_q     <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_count_q <= err_count_d;
      stuck_q     <= stuck_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign stuck_zero = stuck_q;

`ifdef LFSR_CHK_PERIOD_EN
  lfsr_period_meter #(
    .CNT_W(CNT_W)
  ) u_period_meter (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .sample_valid(valid),
    .in_locked   (state_q == LOCKED),
    .sample      (lfsr_in),
    .period      (period),
    .period_valid(period_valid)
  );
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: directed scenarios plus a randomized stream
// checked against a sample-level behavioural model.
module tb_lfsr_seq_checker;
  import lfsr_pkg::*;

  localparam int TAP1 = 2;
  localparam int TAP2 = 4;
  localparam int LOCK_N = 4;
  localparam int LOSS_N = 3;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset, valid, clear;
  logic [7:0]    lfsr_in;
  logic          locked, err_pulse, stuck_zero, period_valid;
  logic [CW-1:0] err_count, period;

  int n_checks = 0;
  int n_fail   = 0;

  lfsr_seq_checker #(
    .TAP_ONE(TAP1), .TAP_TWO(TAP2), .LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .valid(valid), .lfsr_in(lfsr_in), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .stuck_zero(stuck_zero), .period(period), .period_valid(period_valid)
  );

  always #5 clock = ~clock;

  // Behavioural model: tracks streaks of good predictions and misses per sample.
  bit            m_have_prev, m_locked, m_err_pulse, m_stuck, m_pvalid, m_armed;
  logic [7:0]    m_prev, m_ref;
  int            m_streak, m_misses;
  logic [CW-1:0] m_err_count, m_period, m_run;

  task automatic model_clear();
    m_have_prev = 0; m_locked = 0; m_err_pulse = 0; m_stuck = 0; m_pvalid = 0;
    m_armed = 0; m_prev = '0; m_ref = '0; m_streak = 0; m_misses = 0;
    m_err_count = '0; m_period = '0; m_run = '0;
  endtask

  task automatic model_apply(input bit v, input logic [7:0] d, input bit c);
    bit good;
    m_err_pulse = 0;
    m_pvalid    = 0;
    if (c) begin
      model_clear();
      return;
    end
    if (!m_locked) m_armed = 0;
    if (!v) return;
`ifdef LFSR_CHK_PERIOD_EN
    if (m_locked) begin
      if (!m_armed) begin
        m_armed = 1; m_ref = d; m_run = '0;
      end else begin
        if (m_run != {CW{1'b1}}) m_run = m_run + 1;
        if (d == m_ref) begin
          m_period = m_run; m_pvalid = 1; m_run = '0;
        end
      end
    end
`endif
    good = m_have_prev && (d == lfsr_next(m_prev, TAP1, TAP2)) && (d != 0);
    if (!m_have_prev) begin
      m_have_prev = 1;
      m_streak    = 0;
    end else if (!m_locked) begin
      if (good) begin
        m_streak++;
        if (m_streak == LOCK_N) begin
          m_locked = 1; m_misses = 0;
        end
      end else m_streak = 0;
    end else if (good) begin
      m_misses = 0;
    end else begin
      m_err_pulse = 1;
      if (m_err_count != {CW{1'b1}}) m_err_count = m_err_count + 1;
      m_misses++;
      if (m_misses == LOSS_N) begin
        m_locked = 0; m_streak = 0;
      end
    end
    m_stuck = (d == 0);
    m_prev  = d;
  endtask

  // Drive one cycle, advance the model, then settle past the edge.
  task automatic step(input bit v, input logic [7:0] d, input bit c);
    valid = v; lfsr_in = d; clear = c;
    @(posedge clock);
    model_apply(v, d, c);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] seq [7];
    seq = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88, 8'h00};
    #12;
    n_checks++;
    if ({locked, err_pulse, err_count, stuck_zero, period, period_valid} !== '0) begin
      n_fail++; $display("FAIL reset_initial: outputs not all zero");
    end
    @(negedge clock); reset = 1'b1;
    foreach (seq[i]) step(1, seq[i], 0);
    n_checks++;
    if (err_count !== 16'd1 || stuck_zero !== 1'b1 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_precond: got cnt=%0d stuck=%0b lock=%0b, expected 1 1 1",
               err_count, stuck_zero, locked);
    end
    #2; reset = 1'b0; model_clear(); #1;
    n_checks++;
    if ({locked, err_pulse, err_count, stuck_zero, period, period_valid} !== '0) begin
      n_fail++; $display("FAIL reset_async: outputs not zero while reset low");
    end
    @(negedge clock); reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1, seq[i], 0);
      n_checks++;
      if (locked !== (i == 4)) begin
        n_fail++; $display("FAIL reset_relock[%0d]: got %0b expected %0b", i, locked, i == 4);
      end
    end
  endtask

  task automatic test_lock();
    logic [7:0] seq [6];
    seq = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(1, seq[i], 0);
      n_checks++;
      if (locked !== (i >= 4) || err_count !== '0) begin
        n_fail++;
        $display("FAIL lock[%0d]: got lock=%0b cnt=%0d expected lock=%0b cnt=0",
                 i, locked, err_count, i >= 4);
      end
    end
  endtask

  task automatic test_single_error(output logic [7:0] last);
    logic [7:0] v;
    step(1, 8'h55, 0);
    n_checks++;
    if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL single_err: got pulse=%0b cnt=%0d lock=%0b expected 1 1 1",
               err_pulse, err_count, locked);
    end
    v = 8'h55;
    for (int i = 0; i < 4; i++) begin
      v = lfsr_next(v, TAP1, TAP2);
      step(1, v, 0);
      n_checks++;
      if (err_pulse !== 1'b0 || err_count !== 16'd1 || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL realign[%0d]: got pulse=%0b cnt=%0d lock=%0b expected 0 1 1",
                 i, err_pulse, err_count, locked);
      end
    end
    last = v;
  endtask

  task automatic test_loss(input logic [7:0] start);
    logic [7:0] p, w;
    p = start;
    for (int k = 0; k < 3; k++) begin
      w = ~lfsr_next(p, TAP1, TAP2);
      if (w == 8'h00) w = 8'h01;
      step(1, w, 0);
      p = w;
      n_checks++;
      if (err_pulse !== 1'b1 || err_count !== CW'(2 + k) || locked !== (k < 2)) begin
        n_fail++;
        $display("FAIL loss[%0d]: got pulse=%0b cnt=%0d lock=%0b expected 1 %0d %0b",
                 k, err_pulse, err_count, locked, 2 + k, k < 2);
      end
    end
    for (int k = 0; k < 4; k++) begin
      p = lfsr_next(p, TAP1, TAP2);
      step(1, p, 0);
      n_checks++;
      if (locked !== (k == 3) || err_pulse !== 1'b0 || err_count !== 16'd4) begin
        n_fail++;
        $display("FAIL relock[%0d]: got lock=%0b pulse=%0b cnt=%0d expected %0b 0 4",
                 k, locked, err_pulse, err_count, k == 3);
      end
    end
  endtask

  task automatic test_zero_clear();
    logic [7:0] seq [6];
    seq = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h00};
    step(0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 8'h00, 0);
      n_checks++;
      if (stuck_zero !== 1'b1 || locked !== 1'b0 || err_count !== '0) begin
        n_fail++;
        $display("FAIL zero[%0d]: got stuck=%0b lock=%0b cnt=%0d expected 1 0 0",
                 i, stuck_zero, locked, err_count);
      end
    end
    step(1, 8'h01, 0);
    n_checks++;
    if (stuck_zero !== 1'b0) begin
      n_fail++; $display("FAIL zero_release: got %0b expected 0", stuck_zero);
    end
    step(0, 0, 1);
    foreach (seq[i]) step(1, seq[i], 0);
    step(1, 8'h00, 1);
    n_checks++;
    if (stuck_zero !== 1'b0 || err_count !== '0 || locked !== 1'b0 || err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_valid: got stuck=%0b cnt=%0d lock=%0b pulse=%0b expected 0 0 0 0",
               stuck_zero, err_count, locked, err_pulse);
    end
  endtask

  task automatic test_period();
    logic [7:0] v;
    int cyc, pulses;
    v = 8'h01; cyc = 0;
    do begin
      v = lfsr_next(v, TAP1, TAP2); cyc++;
    end while (v != 8'h01 && cyc < 1000);
    step(0, 0, 1);
    v = 8'h01; pulses = 0;
    step(1, v, 0);
    for (int i = 1; i <= 5 + 2 * cyc + 2; i++) begin
      v = lfsr_next(v, TAP1, TAP2);
      step(1, v, 0);
      if (period_valid === 1'b1) pulses++;
`ifdef LFSR_CHK_PERIOD_EN
      n_checks++;
      if (period_valid !== (i == 5 + cyc || i == 5 + 2 * cyc) ||
          (period_valid === 1'b1 && period !== CW'(cyc))) begin
        n_fail++;
        $display("FAIL period[%0d]: got pv=%0b per=%0d expected pv=%0b per=%0d",
                 i, period_valid, period, i == 5 + cyc || i == 5 + 2 * cyc, cyc);
      end
`else
      n_checks++;
      if (period !== '0 || period_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL period_off[%0d]: got per=%0d pv=%0b expected 0 0",
                 i, period, period_valid);
      end
`endif
    end
`ifdef LFSR_CHK_PERIOD_EN
    n_checks++;
    if (pulses != 2) begin
      n_fail++; $display("FAIL period_pulses: got %0d expected 2", pulses);
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] gen, d;
    int r;
    step(0, 0, 1);
    gen = 8'h01;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      d = (gen == 8'h00) ? 8'h01 : lfsr_next(gen, TAP1, TAP2);
      if (r < 3) begin
        step(bit'($urandom_range(0, 1)), 8'($urandom), 1);
      end else if (r < 13) begin
        step(0, 8'($urandom), 0);
      end else if (r < 20) begin
        d = 8'($urandom); step(1, d, 0); gen = d;
      end else if (r < 23) begin
        step(1, 8'h00, 0); gen = 8'h00;
      end else begin
        step(1, d, 0); gen = d;
      end
      n_checks++;
      if (locked !== m_locked || err_pulse !== m_err_pulse || err_count !== m_err_count ||
          stuck_zero !== m_stuck || period !== m_period || period_valid !== m_pvalid) begin
        n_fail++;
        $display("FAIL random[%0d]: got l=%0b p=%0b c=%0d s=%0b per=%0d pv=%0b expected %0b %0b %0d %0b %0d %0b",
                 i, locked, err_pulse, err_count, stuck_zero, period, period_valid,
                 m_locked, m_err_pulse, m_err_count, m_stuck, m_period, m_pvalid);
      end
    end
  endtask

  initial begin
    logic [7:0] last;
    reset = 1'b0; valid = 1'b0; clear = 1'b0; lfsr_in = '0;
    model_clear();
    test_reset();
    test_lock();
    test_single_error(last);
    test_loss(last);
    test_zero_clear();
    test_period();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
